// File: rtl/bcd_countdown_2digit.sv
// Two-digit packed-BCD countdown timer (99..00) with preload, start/pause
// control, optional auto-reload and a one-cycle done pulse on reaching 00.
module bcd_countdown_2digit #(
    parameter int TICK_DIV    = 1,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic [7:0] d_i,
    input  logic       start_i,
    input  logic       pause_i,
    output logic [7:0] q_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t        state_q;
    logic [7:0]    q_q, rld_q;
    logic [PW-1:0] pre_q;
    logic          busy_q, done_q, err_q;

    logic [7:0] dec_d;
    logic       d_valid;
    logic       tick;

    assign d_valid = (d_i[7:4] <= 4'd9) && (d_i[3:0] <= 4'd9);
    assign tick    = (pre_q == PRE_LAST);

    // Borrow from tens when units underflow; only used while q_q != 00.
    always_comb begin
        dec_d = q_q;
        if (q_q[3:0] != 4'd0) dec_d[3:0] = q_q[3:0] - 4'd1;
        else                  dec_d      = {q_q[7:4] - 4'd1, 4'd9};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            q_q     <= 8'h00;
            rld_q   <= 8'h00;
            pre_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                pre_q   <= '0;
                if (d_valid) begin
                    q_q   <= d_i;
                    rld_q <= d_i;
                    err_q <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i && (q_q != 8'h00)) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            pre_q   <= '0;
                        end
                    end
                    RUN: begin
                        if (pause_i) begin
                            state_q <= HOLD;
                        end else if (!tick) begin
                            pre_q <= pre_q + 1'b1;
                        end else begin
                            pre_q <= '0;
                            // Sitting at 00 in RUN only happens with auto-reload.
                            if (q_q == 8'h00) begin
                                if (rld_q == 8'h00) begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                end else begin
                                    q_q <= rld_q;
                                end
                            end else begin
                                q_q <= dec_d;
                                if (dec_d == 8'h00) begin
                                    done_q <= 1'b1;
                                    if (!AUTO_RELOAD) begin
                                        state_q <= IDLE;
                                        busy_q  <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (!pause_i) state_q <= RUN;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q_o    = q_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_countdown_2digit.sv
// Directed bench for bcd_countdown_2digit: three instances cover the plain,
// auto-reload and divided-tick configurations from one shared stimulus.
module tb_bcd_countdown_2digit;

    logic       clk = 1'b0;
    logic       rst_n, ld, st, pz;
    logic [7:0] d;
    logic [7:0] q_w    [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       err_w  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_countdown_2digit #(.TICK_DIV(1), .AUTO_RELOAD(1'b0)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .load_i(ld), .d_i(d), .start_i(st), .pause_i(pz),
        .q_o(q_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .err_o(err_w[0]));
    bcd_countdown_2digit #(.TICK_DIV(1), .AUTO_RELOAD(1'b1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .load_i(ld), .d_i(d), .start_i(st), .pause_i(pz),
        .q_o(q_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .err_o(err_w[1]));
    bcd_countdown_2digit #(.TICK_DIV(4), .AUTO_RELOAD(1'b0)) u2 (
        .clk_i(clk), .rst_n_i(rst_n), .load_i(ld), .d_i(d), .start_i(st), .pause_i(pz),
        .q_o(q_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]), .err_o(err_w[2]));

    typedef struct {
        bit         rst_n, ld, st, pz;
        logic [7:0] d;
        int         sel;
        logic [7:0] eq;
        bit         eb, ed, ee;
        string      tag;
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit r, bit l, logic [7:0] dv, bit s, bit p, int sel,
                                logic [7:0] eq, bit eb, bit ed, bit ee, string tag);
        vec_t v;
        v.rst_n = r; v.ld = l; v.d = dv; v.st = s; v.pz = p; v.sel = sel;
        v.eq = eq; v.eb = eb; v.ed = ed; v.ee = ee; v.tag = tag;
        tv.push_back(v);
    endfunction

    task automatic chk(string tag, logic [10:0] act, logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got q=%h busy=%b done=%b err=%b, want q=%h busy=%b done=%b err=%b",
                     tag, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk1(string tag, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        rst_n = v.rst_n; ld = v.ld; d = v.d; st = v.st; pz = v.pz;
        @(posedge clk); #1;
        chk(v.tag, {q_w[v.sel], busy_w[v.sel], done_w[v.sel], err_w[v.sel]},
                   {v.eq, v.eb, v.ed, v.ee});
    endtask

    initial begin
        logic [7:0] seq12 [11];
        logic [7:0] seq20 [15];
        int done_edge, done_cnt;
        vec_t v;

        rst_n = 1'b1; ld = 1'b0; st = 1'b0; pz = 1'b0; d = 8'h00;
        seq12 = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        seq20 = '{8'h19, 8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10,
                  8'h09, 8'h08, 8'h07, 8'h06, 8'h05};

        // Basic countdown 12 -> 00 on u0
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "reset");
        add(1, 1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0, "load12");
        add(1, 0, 8'h00, 1, 0, 0, 8'h12, 1, 0, 0, "start12");
        foreach (seq12[i])
            add(1, 0, 8'h00, (i == 3), 0, 0, seq12[i], 1, 0, 0, "run12");
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, "reach00");
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "after00");
        // Bad BCD load keeps Q and sets err; good load clears it
        add(1, 1, 8'h25, 0, 0, 0, 8'h25, 0, 0, 0, "load25");
        add(1, 1, 8'h3A, 0, 0, 0, 8'h25, 0, 0, 1, "load3A");
        add(1, 1, 8'h07, 0, 0, 0, 8'h07, 0, 0, 0, "load07");
        // Pause at 08 for five cycles
        add(1, 1, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0, "load10");
        add(1, 0, 8'h00, 1, 0, 0, 8'h10, 1, 0, 0, "start10");
        add(1, 0, 8'h00, 0, 0, 0, 8'h09, 1, 0, 0, "run09");
        add(1, 0, 8'h00, 0, 0, 0, 8'h08, 1, 0, 0, "run08");
        for (int i = 0; i < 5; i++)
            add(1, 0, 8'h00, 0, 1, 0, 8'h08, 1, 0, 0, "hold08");
        add(1, 0, 8'h00, 0, 0, 0, 8'h08, 1, 0, 0, "release");
        add(1, 0, 8'h00, 0, 0, 0, 8'h07, 1, 0, 0, "resume07");
        add(1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "load00_abort");
        // Reset mid-run, err also set beforehand
        add(1, 1, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0, "load20");
        add(1, 1, 8'hAA, 0, 0, 0, 8'h20, 0, 0, 1, "loadAA");
        add(1, 0, 8'h00, 1, 0, 0, 8'h20, 1, 0, 1, "start20");
        foreach (seq20[i])
            add(1, 0, 8'h00, 0, 0, 0, seq20[i], 1, 0, 1, "run20");
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "rst_midrun");
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, "start_at00");
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "idle_at00");
        // Auto-reload on u1
        add(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, "ar_reset");
        add(1, 1, 8'h02, 0, 0, 1, 8'h02, 0, 0, 0, "ar_load02");
        add(1, 0, 8'h00, 1, 0, 1, 8'h02, 1, 0, 0, "ar_start");
        add(1, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, "ar_01a");
        add(1, 0, 8'h00, 0, 0, 1, 8'h00, 1, 1, 0, "ar_00a");
        add(1, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0, "ar_reload");
        add(1, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, "ar_01b");
        add(1, 0, 8'h00, 0, 0, 1, 8'h00, 1, 1, 0, "ar_00b");
        add(1, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0, "ar_reload2");
        add(1, 1, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, "ar_load00");
        add(1, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, 0, "ar_start_ign");
        add(1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, "ar_idle");
        // Divided tick on u2: load wins over a simultaneous start
        add(0, 0, 8'h00, 0, 0, 2, 8'h00, 0, 0, 0, "div_reset");
        add(1, 1, 8'h05, 1, 0, 2, 8'h05, 0, 0, 0, "div_ldstart");
        add(1, 0, 8'h00, 0, 0, 2, 8'h05, 0, 0, 0, "div_stay_idle");
        add(1, 1, 8'h03, 0, 0, 2, 8'h03, 0, 0, 0, "div_load03");
        add(1, 0, 8'h00, 1, 0, 2, 8'h03, 1, 0, 0, "div_start");

        foreach (tv[i]) begin
            v = tv[i];
            step(v);
        end
        st = 1'b0;

        // Divided tick: decrements every 4th edge, done after the 12th edge
        done_edge = -1;
        done_cnt  = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (e == 3)  chk1("div_q_e3",  int'(q_w[2]), 8'h03);
            if (e == 4)  chk1("div_q_e4",  int'(q_w[2]), 8'h02);
            if (e == 8)  chk1("div_q_e8",  int'(q_w[2]), 8'h01);
            if (e == 11) chk1("div_busy_e11", int'(busy_w[2]), 1);
            if (done_w[2]) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
        end
        chk1("div_done_edge", done_edge, 12);
        chk1("div_done_cnt", done_cnt, 1);
        chk("div_final", {q_w[2], busy_w[2], done_w[2], err_w[2]}, {8'h00, 1'b0, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
